seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
- Downstream consumer of the 16-bit ripple-carry sum built from the full-adder cells.
- Captures sum[15:0] and carry-out on a load strobe, then time-multiplexes four common-anode hex digits.
- Adds optional leading-zero blanking, an overflow decimal point, and inter-digit blanking to suppress ghosting.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is lit per slot (must be >=1).
BLANK_CYCLES, 16, cycles with all anodes off between digit slots (0 = no blank phase).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
load  input  1  single-cycle strobe: capture value/carry.
value  input  16  adder sum; nibble k drives digit k (digit 0 rightmost).
carry  input  1  adder carry-out; shown as decimal point on digit 3.
blank_lz  input  1  1 = suppress leading-zero digits.
an  output  4  anode enables, active-low, bit k = digit k.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low.

Behaviour:
- Registers:
  - shadow (value, carry, pending flag)
  - display (value, carry)
  - state: IDLE / SHOW / BLANK
  - idx[1:0]
  - cnt, wide enough for max(REFRESH_DIV, BLANK_CYCLES).
- All outputs are registered and updated on the same edge as the state, so an/seg/dp always match the current state and idx.
- Reset (any cycle, including mid-frame):
  - Outputs: an=4'hF, seg=7'h7F, dp=1.
  - Internal: state=IDLE, idx=0, cnt=0, shadow and display cleared, pending=0.
  - Takes effect on the next edge.
- IDLE:
  - Outputs off.
  - On load: display<=value/carry directly, state->SHOW, idx=0, cnt=0.
  - Digit 0 is lit in the cycle after the load edge.
- SHOW:
  - an has bit idx low and all other bits high; seg=hex(display nibble idx); cnt increments.
  - At cnt==REFRESH_DIV-1: cnt=0, state->BLANK.
  - If BLANK_CYCLES==0, go straight to the next digit (the rules below still apply).
- BLANK:
  - an=4'hF, seg=7'h7F, dp=1.
  - After BLANK_CYCLES cycles: idx=idx+1 mod 4, state->SHOW.
- Frame:
  - Digit order is 0,1,2,3,0,...
  - Frame period = 4*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Load while not IDLE:
  - shadow<=value/carry, pending=1.
  - Multiple loads within one frame: last one wins.
  - On the idx 3->0 wrap edge: if pending, display<=shadow and pending=0.
  - Load on the same edge as the wrap: the newly loaded value goes directly to display, pending=0.
  - The display never changes mid-frame.
- Hex decode (seg hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (blank_lz=1, sampled each cycle):
  - Digit k>=1 is suppressed when nibbles k..3 of display are all zero.
  - A suppressed slot has an=4'hF and seg=7'h7F for its whole SHOW period; timing is unchanged.
  - Digit 0 is never suppressed, so value 0 shows "0".
- dp:
  - dp=0 only in SHOW with idx==3 and display carry==1.
  - If digit 3 is suppressed by blanking, dp is still driven and an[3]=0, so the overflow indication stays visible.
  - Otherwise dp=1.
- Counter wrap: cnt never exceeds its terminal value. idx wraps naturally at 2 bits.

Test Plan:
(All with REFRESH_DIV=4, BLANK_CYCLES=1.)
1. Reset held 3 cycles, then 20 idle cycles with no load -> an=F, seg=7F, dp=1 throughout.
2. Load value=16'h12AF, carry=0, blank_lz=0 -> 1 cycle after load: an=1110, seg=0E for 4 cycles; then an=F for 1 cycle; then an=1101 seg=08, an=1011 seg=24, an=0111 seg=79. Digit 0 repeats 20 cycles after its first slot.
3. value=16'h0005, blank_lz=1 -> an=1110, seg=12 in slot 0; slots 1-3 show an=F, seg=7F. With carry=1, slot 3 shows an=0111, seg=7F, dp=0.
4. value=16'hFFFF, carry=1, blank_lz=0 -> dp=0 only while an=0111 (seg=0E); dp=1 in every other cycle.
5. Display 16'h12AF. Load 16'h3333 during digit 1, then 16'h4444 during digit 2 -> digits 2-3 still show 2,1. Next frame shows all digits as 4 (seg=19); 3333 is never displayed.
6. Assert reset during SHOW of digit 2 -> next edge: an=F, seg=7F, pending cleared. Outputs stay off until a new load, which restarts at digit 0.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode hex scanner for a 16-bit adder sum and its carry-out.
// Mid-frame loads wait in a shadow register and reach the display only at the frame wrap.
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        carry,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
    logic             shadow_car_q, shadow_car_d, disp_car_q, disp_car_d;
    logic             pending_q, pending_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             wrap;
    logic [3:0]       nibble;
    logic             suppress;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through this block infers a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_val_d = shadow_val_q;
        shadow_car_d = shadow_car_q;
        disp_val_d   = disp_val_q;
        disp_car_d   = disp_car_q;
        pending_d    = pending_q;

        case (state_q)
            IDLE: if (load) begin
                state_d = SHOW;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
            SHOW: if (cnt_q == SHOW_LAST) begin
                cnt_d = '0;
                if (BLANK_CYCLES == 0) idx_d = idx_q + 2'd1;
                else                   state_d = BLANK;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            BLANK: if (cnt_q == BLANK_LAST) begin
                cnt_d   = '0;
                idx_d   = idx_q + 2'd1;
                state_d = SHOW;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        wrap = (state_q != IDLE) && (idx_q == 2'd3) && (idx_d == 2'd0);
        if (state_q == IDLE || wrap) begin
            if (load) begin
                disp_val_d = value;
                disp_car_d = carry;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_car_d = shadow_car_q;
                pending_d  = 1'b0;
            end
        end else if (load) begin
            shadow_val_d = value;
            shadow_car_d = carry;
            pending_d    = 1'b1;
        end

        // Outputs are decoded from the next state so they land on the same edge as it.
        an_d     = 4'hF;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        nibble   = disp_val_d[{idx_d, 2'b00} +: 4];
        suppress = blank_lz && (idx_d != 2'd0) && ((disp_val_d >> {idx_d, 2'b00}) == 16'd0);
        if (state_d == SHOW) begin
            if (!suppress) begin
                an_d[idx_d] = 1'b0;
                seg_d       = hex7(nibble);
            end
            if (idx_d == 2'd3 && disp_car_d) begin
                an_d[3] = 1'b0;
                dp_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            shadow_val_q <= 16'd0;
            shadow_car_q <= 1'b0;
            disp_val_q   <= 16'd0;
            disp_car_q   <= 1'b0;
            pending_q    <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_val_q <= shadow_val_d;
            shadow_car_q <= shadow_car_d;
            disp_val_q   <= disp_val_d;
            disp_car_q   <= disp_car_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: fixed vector tables, hand-written corner sequences and a
// randomized run against a frame-position reference model.
module tb_seven_seg_scan_driver;
    localparam int R     = 4;
    localparam int B     = 1;
    localparam int SLOT  = R + B;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'd0;
    logic        carry = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] dut_out;

    int n_cmp  = 0;
    int n_fail = 0;

    seven_seg_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .carry(carry),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;
    assign dut_out = {an, seg, dp};

    // Reference model: time since the first load, the shown value, and the newest mid-frame load.
    logic [6:0]  hex_tab [16];
    bit          m_run;
    int          m_t;
    logic [15:0] m_disp, m_shadow;
    bit          m_car, m_scar, m_pend;
    logic [11:0] m_out;

    typedef struct {
        bit          rst;
        bit          ld;
        logic [15:0] val;
        bit          car;
        bit          blz;
        int          n;
        logic [3:0]  an;
        logic [6:0]  seg;
        bit          dp;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit rst, bit ld, logic [15:0] val, bit car, bit blz, int n,
                                logic [3:0] e_an, logic [6:0] e_seg, bit e_dp);
        vec_t v;
        v.rst = rst; v.ld = ld; v.val = val; v.car = car; v.blz = blz; v.n = n;
        v.an = e_an; v.seg = e_seg; v.dp = e_dp;
        return v;
    endfunction

    task automatic model_step();
        int         slot;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (reset) begin
            m_run = 0; m_t = 0; m_disp = 0; m_car = 0; m_shadow = 0; m_scar = 0; m_pend = 0;
        end else if (!m_run) begin
            if (load) begin
                m_run = 1; m_t = 0; m_disp = value; m_car = carry;
            end
        end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) begin
                if (load) begin
                    m_disp = value; m_car = carry; m_pend = 0;
                end else if (m_pend) begin
                    m_disp = m_shadow; m_car = m_scar; m_pend = 0;
                end
            end else if (load) begin
                m_shadow = value; m_scar = carry; m_pend = 1;
            end
        end
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        slot = m_t / SLOT;
        if (m_run && (m_t % SLOT) < R) begin
            if (!(blank_lz && slot > 0 && (m_disp >> (4 * slot)) == 16'd0)) begin
                e_an[slot] = 1'b0;
                e_seg = hex_tab[(m_disp >> (4 * slot)) & 16'hF];
            end
            if (slot == 3 && m_car) begin
                e_an[3] = 1'b0;
                e_dp = 1'b0;
            end
        end
        m_out = {e_an, e_seg, e_dp};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                     name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic check_model(input string name);
        check(name, dut_out, m_out);
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0;
        tick();
        check("reset", dut_out, 12'hFFF);
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v, input bit c, input bit blz);
        load = 1'b1; value = v; carry = c; blank_lz = blz;
        tick();
        load = 1'b0;
    endtask

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_run = 0; m_t = 0; m_disp = 0; m_car = 0; m_shadow = 0; m_scar = 0; m_pend = 0;
        m_out = 12'hFFF;

        // Reset held three cycles, then idle with no load.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset hold %0d", i), dut_out, 12'hFFF);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle %0d", i), dut_out, 12'hFFF);
        end

        // Plain scan of 12AF.
        tv.push_back(mk(0, 1, 16'h12AF, 0, 0, 4, 4'hE, 7'h0E, 1));
        tv.push_back(mk(0, 0, 16'h12AF, 0, 0, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 0, 16'h12AF, 0, 0, 4, 4'hD, 7'h08, 1));
        tv.push_back(mk(0, 0, 16'h12AF, 0, 0, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 0, 16'h12AF, 0, 0, 4, 4'hB, 7'h24, 1));
        tv.push_back(mk(0, 0, 16'h12AF, 0, 0, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 0, 16'h12AF, 0, 0, 4, 4'h7, 7'h79, 1));
        tv.push_back(mk(0, 0, 16'h12AF, 0, 0, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 0, 16'h12AF, 0, 0, 1, 4'hE, 7'h0E, 1));
        // Leading-zero blanking of 0005, without and with carry.
        tv.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 1, 16'h0005, 0, 1, 4, 4'hE, 7'h12, 1));
        tv.push_back(mk(0, 0, 16'h0005, 0, 1, 16, 4'hF, 7'h7F, 1));
        tv.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 1, 16'h0005, 1, 1, 4, 4'hE, 7'h12, 1));
        tv.push_back(mk(0, 0, 16'h0005, 1, 1, 11, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 0, 16'h0005, 1, 1, 4, 4'h7, 7'h7F, 0));
        tv.push_back(mk(0, 0, 16'h0005, 1, 1, 1, 4'hF, 7'h7F, 1));
        // Overflow point on FFFF.
        tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 1, 16'hFFFF, 1, 0, 4, 4'hE, 7'h0E, 1));
        tv.push_back(mk(0, 0, 16'hFFFF, 1, 0, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 0, 16'hFFFF, 1, 0, 4, 4'hD, 7'h0E, 1));
        tv.push_back(mk(0, 0, 16'hFFFF, 1, 0, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 0, 16'hFFFF, 1, 0, 4, 4'hB, 7'h0E, 1));
        tv.push_back(mk(0, 0, 16'hFFFF, 1, 0, 1, 4'hF, 7'h7F, 1));
        tv.push_back(mk(0, 0, 16'hFFFF, 1, 0, 4, 4'h7, 7'h0E, 0));
        tv.push_back(mk(0, 0, 16'hFFFF, 1, 0, 1, 4'hF, 7'h7F, 1));

        for (int r = 0; r < tv.size(); r++) begin
            for (int k = 0; k < tv[r].n; k++) begin
                reset = tv[r].rst; load = tv[r].ld && (k == 0);
                value = tv[r].val; carry = tv[r].car; blank_lz = tv[r].blz;
                tick();
                check($sformatf("vec %0d.%0d", r, k), dut_out, {tv[r].an, tv[r].seg, tv[r].dp});
            end
        end
        reset = 1'b0; load = 1'b0;

        // Two mid-frame loads: only the last one appears, and only from the next frame.
        do_reset();
        do_load(16'h12AF, 0, 0);
        for (int t = 1; t < 40; t++) begin
            load = (t == 6) || (t == 11);
            value = (t == 6) ? 16'h3333 : 16'h4444;
            tick();
            load = 1'b0;
            check_model($sformatf("shadow t=%0d", t));
            if (t == 12) check("shadow dig2 old", dut_out, {4'hB, 7'h24, 1'b1});
            if (t == 17) check("shadow dig3 old", dut_out, {4'h7, 7'h79, 1'b1});
            if (t == 21) check("shadow dig0 new", dut_out, {4'hE, 7'h19, 1'b1});
            if (t == 26) check("shadow dig1 new", dut_out, {4'hD, 7'h19, 1'b1});
            if (t == 31) check("shadow dig2 new", dut_out, {4'hB, 7'h19, 1'b1});
            if (t == 36) check("shadow dig3 new", dut_out, {4'h7, 7'h19, 1'b1});
        end

        // Reset mid-frame with a load pending; the pending value must be forgotten.
        do_reset();
        do_load(16'h12AF, 0, 0);
        for (int t = 1; t <= 11; t++) begin
            load = (t == 7); value = 16'h5555;
            tick();
            load = 1'b0;
        end
        check("midframe dig2", dut_out, {4'hB, 7'h24, 1'b1});
        reset = 1'b1;
        tick();
        check("midframe reset", dut_out, 12'hFFF);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("post-reset idle %0d", i), dut_out, 12'hFFF);
        end
        do_load(16'h00A0, 0, 0);
        check("reload dig0", dut_out, {4'hE, 7'h40, 1'b1});
        for (int t = 1; t <= 20; t++) begin
            tick();
            check_model($sformatf("reload t=%0d", t));
            if (t == 5)  check("reload dig1", dut_out, {4'hD, 7'h08, 1'b1});
            if (t == 20) check("reload no stale", dut_out, {4'hE, 7'h40, 1'b1});
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 4))
                0:       value = 16'h0000;
                1:       value = 16'($urandom) & 16'h000F;
                2:       value = 16'($urandom) & 16'h00FF;
                3:       value = 16'($urandom) & 16'h0FFF;
                default: value = 16'($urandom);
            endcase
            carry = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            tick();
            check_model($sformatf("random %0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
